// File: rtl/defect_zone_bbox.sv
// defect_zone_bbox: per-frame foreground bounding boxes of a binarised pixel stream,
// split into vertical zones, with vs/de delayed for a downstream overlay.
module defect_zone_bbox #(
    parameter int unsigned COORD_WID    = 11,
    parameter int unsigned NUM_ZONES    = 3,
    parameter int unsigned ZONE_SHIFT   = 8,
    parameter int unsigned CNT_WID      = 20,
    parameter int unsigned MIN_PIX      = 16,
    parameter int unsigned DELAY_CYCLES = 2
) (
    input  logic                           pixclk_in,
    input  logic                           rstn_out,
    input  logic                           bin2_vs,
    input  logic                           bin2_de,
    input  logic                           bin2_data,
    output logic [NUM_ZONES*COORD_WID-1:0] zone_x_min,
    output logic [NUM_ZONES*COORD_WID-1:0] zone_x_max,
    output logic [NUM_ZONES*COORD_WID-1:0] zone_y_min,
    output logic [NUM_ZONES*COORD_WID-1:0] zone_y_max,
    output logic [NUM_ZONES*CNT_WID-1:0]   zone_cnt,
    output logic [NUM_ZONES-1:0]           zone_valid,
    output logic                           frame_done,
    output logic                           point_vs,
    output logic                           point_de
);

    localparam logic [COORD_WID-1:0] COORD_MAX = '1;
    localparam logic [CNT_WID-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

    state_t state_q;
    state_t state_d;
    logic   snap_c;

    logic                 vs_d;
    logic                 de_d;
    logic                 vs_rise_c;
    logic                 de_fall_c;
    logic                 fg_pix_c;
    logic [COORD_WID-1:0] x_cnt;
    logic [COORD_WID-1:0] y_cnt;
    logic [COORD_WID-1:0] zone_idx_c;

    logic [COORD_WID-1:0] acc_xmin [NUM_ZONES];
    logic [COORD_WID-1:0] acc_xmax [NUM_ZONES];
    logic [COORD_WID-1:0] acc_ymin [NUM_ZONES];
    logic [COORD_WID-1:0] acc_ymax [NUM_ZONES];
    logic [CNT_WID-1:0]   acc_cnt  [NUM_ZONES];

    logic [DELAY_CYCLES-1:0] vs_pipe;
    logic [DELAY_CYCLES-1:0] de_pipe;

    assign vs_rise_c  = bin2_vs & ~vs_d;
    assign de_fall_c  = ~bin2_de & de_d;
    // vs wins over any pixel arriving in the same cycle
    assign fg_pix_c   = bin2_de & bin2_data & ~bin2_vs;
    assign zone_idx_c = x_cnt >> ZONE_SHIFT;

    // Previous-cycle sync copies for edge detection
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= bin2_vs;
            de_d <= bin2_de;
        end
    end

    // Pixel (x) and line (y) coordinates recovered from the sync stream, saturating
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (!bin2_de) begin
                x_cnt <= '0;
            end else if (x_cnt != COORD_MAX) begin
                x_cnt <= x_cnt + COORD_WID'(1);
            end
            if (bin2_vs) begin
                y_cnt <= '0;
            end else if (de_fall_c && (y_cnt != COORD_MAX)) begin
                y_cnt <= y_cnt + COORD_WID'(1);
            end
        end
    end

    // Per-zone running min/max/count for the frame in progress
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                acc_xmin[z] <= COORD_MAX;
                acc_xmax[z] <= '0;
                acc_ymin[z] <= COORD_MAX;
                acc_ymax[z] <= '0;
                acc_cnt[z]  <= '0;
            end
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (bin2_vs) begin
                    acc_xmin[z] <= COORD_MAX;
                    acc_xmax[z] <= '0;
                    acc_ymin[z] <= COORD_MAX;
                    acc_ymax[z] <= '0;
                    acc_cnt[z]  <= '0;
                end else if (fg_pix_c && (zone_idx_c == COORD_WID'(z))) begin
                    if (x_cnt < acc_xmin[z]) acc_xmin[z] <= x_cnt;
                    if (x_cnt > acc_xmax[z]) acc_xmax[z] <= x_cnt;
                    if (y_cnt < acc_ymin[z]) acc_ymin[z] <= y_cnt;
                    if (y_cnt > acc_ymax[z]) acc_ymax[z] <= y_cnt;
                    if (acc_cnt[z] != CNT_MAX) acc_cnt[z] <= acc_cnt[z] + CNT_WID'(1);
                end
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state; the first vs after reset only arms, later ones publish
    always_comb begin
        state_d = state_q;
        snap_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (vs_rise_c) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (vs_rise_c) begin
                    snap_c = 1'b1;
                end else if (bin2_de) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (vs_rise_c) begin
                    snap_c  = 1'b1;
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Publish the finished frame; zones under the pixel threshold read as all-zero
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            zone_x_min <= '0;
            zone_x_max <= '0;
            zone_y_min <= '0;
            zone_y_max <= '0;
            zone_cnt   <= '0;
            zone_valid <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= snap_c;
            if (snap_c) begin
                for (int z = 0; z < NUM_ZONES; z++) begin
                    if (acc_cnt[z] >= CNT_WID'(MIN_PIX)) begin
                        zone_x_min[z*COORD_WID +: COORD_WID] <= acc_xmin[z];
                        zone_x_max[z*COORD_WID +: COORD_WID] <= acc_xmax[z];
                        zone_y_min[z*COORD_WID +: COORD_WID] <= acc_ymin[z];
                        zone_y_max[z*COORD_WID +: COORD_WID] <= acc_ymax[z];
                        zone_cnt[z*CNT_WID +: CNT_WID]       <= acc_cnt[z];
                        zone_valid[z]                        <= 1'b1;
                    end else begin
                        zone_x_min[z*COORD_WID +: COORD_WID] <= '0;
                        zone_x_max[z*COORD_WID +: COORD_WID] <= '0;
                        zone_y_min[z*COORD_WID +: COORD_WID] <= '0;
                        zone_y_max[z*COORD_WID +: COORD_WID] <= '0;
                        zone_cnt[z*CNT_WID +: CNT_WID]       <= '0;
                        zone_valid[z]                        <= 1'b0;
                    end
                end
            end
        end
    end

    // Fixed-latency copy of vs/de for the overlay path
    always_ff @(posedge pixclk_in or negedge rstn_out) begin
        if (!rstn_out) begin
            vs_pipe <= '0;
            de_pipe <= '0;
        end else begin
            vs_pipe[0] <= bin2_vs;
            de_pipe[0] <= bin2_de;
            for (int i = 1; i < DELAY_CYCLES; i++) begin
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    assign point_vs = vs_pipe[DELAY_CYCLES-1];
    assign point_de = de_pipe[DELAY_CYCLES-1];

endmodule

// File: tb/tb_defect_zone_bbox.sv
// Bench for defect_zone_bbox: directed frames plus random sync traffic against a
// pixel-list reference model.
module tb_defect_zone_bbox;

    localparam int unsigned CW   = 11;
    localparam int unsigned NZ   = 2;
    localparam int unsigned ZS   = 3;
    localparam int unsigned NW   = 3;
    localparam int unsigned MP   = 2;
    localparam int unsigned DLY  = 3;
    localparam int          CMAX = (1 << NW) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic vs   = 1'b0;
    logic de   = 1'b0;
    logic data = 1'b0;

    logic [NZ*CW-1:0] zone_x_min, zone_x_max, zone_y_min, zone_y_max;
    logic [NZ*NW-1:0] zone_cnt;
    logic [NZ-1:0]    zone_valid;
    logic             frame_done, point_vs, point_de;

    defect_zone_bbox #(
        .COORD_WID(CW), .NUM_ZONES(NZ), .ZONE_SHIFT(ZS),
        .CNT_WID(NW), .MIN_PIX(MP), .DELAY_CYCLES(DLY)
    ) dut (
        .pixclk_in (clk),
        .rstn_out  (rstn),
        .bin2_vs   (vs),
        .bin2_de   (de),
        .bin2_data (data),
        .zone_x_min(zone_x_min),
        .zone_x_max(zone_x_max),
        .zone_y_min(zone_y_min),
        .zone_y_max(zone_y_max),
        .zone_cnt  (zone_cnt),
        .zone_valid(zone_valid),
        .frame_done(frame_done),
        .point_vs  (point_vs),
        .point_de  (point_de)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fx(input logic [NZ*CW-1:0] v, input int z);
        return 64'(v[z*CW +: CW]);
    endfunction

    function automatic logic [63:0] fc(input logic [NZ*NW-1:0] v, input int z);
        return 64'(v[z*NW +: NW]);
    endfunction

    // ---------------- reference model ----------------
    bit              armed;
    int              mx, my;
    bit              pvs, pde;
    int              px[$];
    int              py[$];
    logic [CW-1:0]   e_xmin[NZ], e_xmax[NZ], e_ymin[NZ], e_ymax[NZ];
    logic [NW-1:0]   e_cnt[NZ];
    logic [NZ-1:0]   e_valid;
    bit              e_done;
    bit              vs_log[8192];
    bit              de_log[8192];
    int              ncyc     = 0;
    int              last_rst = -1;

    task automatic model_reset();
        armed = 0; mx = 0; my = 0; pvs = 0; pde = 0; e_done = 0;
        px.delete(); py.delete();
        e_valid = '0;
        for (int z = 0; z < NZ; z++) begin
            e_xmin[z] = '0; e_xmax[z] = '0; e_ymin[z] = '0; e_ymax[z] = '0; e_cnt[z] = '0;
        end
    endtask

    // Boxes computed directly from the list of foreground pixels seen this frame
    task automatic model_snapshot();
        for (int z = 0; z < NZ; z++) begin
            int n  = 0;
            int xl = 1 << 30;
            int xh = -1;
            int yl = 1 << 30;
            int yh = -1;
            foreach (px[i]) begin
                if ((px[i] >> ZS) == z) begin
                    n++;
                    if (px[i] < xl) xl = px[i];
                    if (px[i] > xh) xh = px[i];
                    if (py[i] < yl) yl = py[i];
                    if (py[i] > yh) yh = py[i];
                end
            end
            if (n >= int'(MP)) begin
                e_xmin[z] = CW'(xl); e_xmax[z] = CW'(xh);
                e_ymin[z] = CW'(yl); e_ymax[z] = CW'(yh);
                e_cnt[z]  = NW'((n > CMAX) ? CMAX : n);
                e_valid[z] = 1'b1;
            end else begin
                e_xmin[z] = '0; e_xmax[z] = '0; e_ymin[z] = '0; e_ymax[z] = '0;
                e_cnt[z]  = '0;
                e_valid[z] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            model_reset();
            vs_log[ncyc] = 0;
            de_log[ncyc] = 0;
            last_rst = ncyc;
        end else begin
            e_done = 0;
            if (vs && !pvs) begin
                if (armed) begin
                    model_snapshot();
                    e_done = 1;
                end
                armed = 1;
            end
            if (vs) begin
                px.delete(); py.delete();
                my = 0;
            end else begin
                if (de && data) begin
                    px.push_back(mx);
                    py.push_back(my);
                end
                if (!de && pde) my++;
            end
            mx  = de ? mx + 1 : 0;
            pvs = vs;
            pde = de;
            vs_log[ncyc] = vs;
            de_log[ncyc] = de;
        end
        ncyc++;
    end

    function automatic bit exp_delayed(input bit is_vs);
        int idx = ncyc - int'(DLY);
        if (idx < 0 || idx <= last_rst) return 1'b0;
        return is_vs ? vs_log[idx] : de_log[idx];
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #1;
        chk("frame_done", 64'(frame_done), 64'(e_done));
        chk("zone_valid", 64'(zone_valid), 64'(e_valid));
        for (int z = 0; z < NZ; z++) begin
            chk($sformatf("x_min[%0d]", z), fx(zone_x_min, z), 64'(e_xmin[z]));
            chk($sformatf("x_max[%0d]", z), fx(zone_x_max, z), 64'(e_xmax[z]));
            chk($sformatf("y_min[%0d]", z), fx(zone_y_min, z), 64'(e_ymin[z]));
            chk($sformatf("y_max[%0d]", z), fx(zone_y_max, z), 64'(e_ymax[z]));
            chk($sformatf("cnt[%0d]", z),   fc(zone_cnt, z),   64'(e_cnt[z]));
        end
        chk("point_vs", 64'(point_vs), 64'(exp_delayed(1'b1)));
        chk("point_de", 64'(point_de), 64'(exp_delayed(1'b0)));
    end

    // ---------------- stimulus ----------------
    bit fg [8][32];

    task automatic clear_fg();
        foreach (fg[y, x]) fg[y][x] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vs = 0; de = 0; data = 0;
        end
    endtask

    task automatic lines(input int len, input int nl);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < len; x++) begin
                @(negedge clk);
                vs = 0; de = 1; data = fg[y][x];
            end
            repeat (4) begin
                @(negedge clk);
                de = 0; data = 0;
            end
        end
    endtask

    // vs high for n cycles; frame_done must pulse only after the first one
    task automatic vs_pulse(input int n, input bit exp_done, input bit de0, input bit data0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vs = 1; de = (i == 0) ? de0 : 1'b0; data = (i == 0) ? data0 : 1'b0;
            @(posedge clk);
            #2;
            chk($sformatf("vs_pulse_done[%0d]", i), 64'(frame_done), 64'((i == 0) ? exp_done : 1'b0));
        end
        @(negedge clk);
        vs = 0; de = 0; data = 0;
    endtask

    // Hand-computed expectations for one zone
    task automatic pin(input string tag, input int z, input int xl, input int xh,
                       input int yl, input int yh, input int c);
        chk({tag, "_xmin"}, fx(zone_x_min, z), 64'(xl));
        chk({tag, "_xmax"}, fx(zone_x_max, z), 64'(xh));
        chk({tag, "_ymin"}, fx(zone_y_min, z), 64'(yl));
        chk({tag, "_ymax"}, fx(zone_y_max, z), 64'(yh));
        chk({tag, "_cnt"},  fc(zone_cnt, z),   64'(c));
    endtask

    initial begin
        int vs_left;
        bit de_run;

        repeat (3) @(negedge clk);
        rstn = 1;
        idle(2);
        chk("reset_valid", 64'(zone_valid), 64'd0);
        pin("reset_z0", 0, 0, 0, 0, 0, 0);

        // first frame only arms; second publishes
        clear_fg();
        fg[1][2] = 1; fg[3][5] = 1;
        lines(16, 8);
        vs_pulse(2, 1'b0, 1'b0, 1'b0);
        chk("first_valid", 64'(zone_valid), 64'd0);
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        pin("first_z0", 0, 2, 5, 1, 3, 2);
        chk("first_valid2", 64'(zone_valid), 64'b01);

        // zone split and pixel threshold
        clear_fg();
        fg[0][7] = 1; fg[0][8] = 1; fg[6][9] = 1;
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        pin("split_z0", 0, 0, 0, 0, 0, 0);
        pin("split_z1", 1, 8, 9, 0, 6, 2);
        chk("split_valid", 64'(zone_valid), 64'b10);

        // out-of-range zone ignored
        clear_fg();
        fg[2][16] = 1;
        lines(20, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        chk("oor_valid", 64'(zone_valid), 64'd0);
        pin("oor_z1", 1, 0, 0, 0, 0, 0);

        // empty frame still publishes; pixel coincident with vs is dropped
        vs_pulse(5, 1'b1, 1'b1, 1'b1);
        chk("empty_valid", 64'(zone_valid), 64'd0);
        clear_fg();
        fg[2][3] = 1;
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        chk("vsprec_valid", 64'(zone_valid), 64'd0);
        pin("vsprec_z0", 0, 0, 0, 0, 0, 0);

        // reset in the middle of a frame
        clear_fg();
        fg[1][1] = 1; fg[2][2] = 1;
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        chk("prerst_valid", 64'(zone_valid), 64'b01);
        lines(16, 4);
        @(negedge clk);
        rstn = 0;
        #1;
        chk("midrst_valid", 64'(zone_valid), 64'd0);
        pin("midrst_z0", 0, 0, 0, 0, 0, 0);
        idle(2);
        rstn = 1;
        lines(16, 4);
        vs_pulse(2, 1'b0, 1'b0, 1'b0);
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        pin("postrst_z0", 0, 1, 2, 1, 2, 2);
        chk("postrst_valid", 64'(zone_valid), 64'b01);

        // counter saturation: ten pixels in zone 0
        clear_fg();
        for (int x = 0; x < 8; x++) fg[0][x] = 1;
        fg[1][0] = 1; fg[1][1] = 1;
        lines(16, 8);
        vs_pulse(2, 1'b1, 1'b0, 1'b0);
        pin("sat_z0", 0, 0, 7, 0, 1, 7);
        chk("sat_valid", 64'(zone_valid), 64'b01);

        // random sync/data traffic with one reset in the middle
        vs_left = 0;
        de_run  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) rstn = 0;
            if (i == 1503) rstn = 1;
            if (vs_left > 0) begin
                vs = 1; vs_left--;
            end else if ($urandom_range(0, 79) == 0) begin
                vs = 1; vs_left = int'($urandom_range(0, 4));
            end else begin
                vs = 0;
            end
            if ($urandom_range(0, 11) == 0) de_run = ~de_run;
            de   = de_run;
            data = 1'($urandom_range(0, 1));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/defect_zone_bbox.md
# defect_zone_bbox

Per-frame foreground bounding-box extractor for the binarised defect stream, partitioned into `NUM_ZONES` vertical strips. It is driven by the bin2 stage (vs/de/1-bit data). It derives coordinates from sync edges rather than fixed image dimensions. It publishes per-zone min/max coordinates, pixel counts and a validity mask once per frame, plus delayed vs/de for downstream overlay.

## Interface
- `COORD_WID`, 11: width of x/y coordinates.
- `NUM_ZONES`, 3: number of vertical strips, range 1..8.
- `ZONE_SHIFT`, 8: zone index = `x >> ZONE_SHIFT`; pixels with index ≥ `NUM_ZONES` are ignored.
- `CNT_WID`, 20: per-zone pixel counter width, saturating.
- `MIN_PIX`, 16: minimum foreground count for a zone to be valid; must be ≥ 1.
- `DELAY_CYCLES`, 2: latency of `point_vs`/`point_de` relative to the inputs; must be ≥ 1.

Ports:
- `pixclk_in`  in  1  pixel clock.
- `rstn_out`  in  1  reset, asynchronous, active-low.
- `bin2_vs`  in  1  frame sync, active high.
- `bin2_de`  in  1  pixel valid.
- `bin2_data`  in  1  1 = foreground (defect) pixel.
- `zone_x_min`, `zone_x_max`, `zone_y_min`, `zone_y_max`  out  `NUM_ZONES*COORD_WID`  per-zone box; zone z occupies bits `[z*COORD_WID +: COORD_WID]`.
- `zone_cnt`  out  `NUM_ZONES*CNT_WID`  per-zone foreground count, same packing.
- `zone_valid`  out  `NUM_ZONES`  bit z = zone z count ≥ `MIN_PIX`.
- `frame_done`  out  1  one-cycle pulse when the outputs update.
- `point_vs`, `point_de`  out  1  inputs delayed by exactly `DELAY_CYCLES` clocks.

## Operation
- **Edge detection:** registered copies `vs_d` and `de_d`.
  - vs rise = `bin2_vs & ~vs_d`.
  - de fall = `~bin2_de & de_d`.
- **x counter:**
  - Cleared whenever `bin2_de` = 0.
  - Increments on each `bin2_de` = 1 cycle.
  - The pixel sampled in a cycle uses the pre-increment value, so the first pixel of a line is x = 0.
  - Saturates at `2^COORD_WID - 1`; no wrap.
- **y counter:**
  - Cleared while `bin2_vs` = 1.
  - Increments on de fall.
  - Saturates at all-ones.
- **Accumulators per zone:** `xmin`/`ymin` hold at all-ones, `xmax`/`ymax` at 0, `cnt` at 0.
  - Held in this cleared state while `bin2_vs` = 1.
  - On `bin2_de & bin2_data & ~bin2_vs` with zone z in range: update min/max with strict compare, and increment `cnt` saturating at all-ones.
- **Frame FSM:**
  - States: IDLE (after reset), ARMED (a vs rise has been seen), RUN.
  - IDLE → ARMED on the first vs rise; no output update and no `frame_done`.
  - ARMED → RUN when `bin2_de` first goes high.
  - RUN → ARMED on vs rise, which also snapshots the accumulators into the outputs and pulses `frame_done`.
  - Vs rise while ARMED (a frame with no de): snapshot still occurs, all zones invalid, `frame_done` pulses.
- **Snapshot rule per zone:**
  - `zone_valid[z]` = (cnt ≥ `MIN_PIX`).
  - If valid, the outputs copy the accumulators.
  - If invalid, that zone's box and cnt outputs are forced to 0.
- **Input precedence:** `bin2_vs` = 1 overrides everything; a foreground pixel coincident with vs is dropped.
- **Sync delay:** `point_vs`/`point_de` are a shift register of depth `DELAY_CYCLES`, independent of the FSM.

## Timing
- **Reset values:** all outputs 0, FSM = IDLE, counters 0, accumulators in the cleared state, delay chains 0.
- **Reset mid-frame:** all state lost; the next vs rise only arms (no `frame_done`).
- **Update latency:**
  - Vs rise sampled at clock edge t.
  - Outputs and `frame_done` = 1 are visible after edge t.
  - `frame_done` returns to 0 after edge t+1.
  - Outputs hold until the next snapshot.
- **Last-pixel guarantee:** a foreground pixel sampled at edge t-1 is included in the snapshot at t.
- **Update rate:** one `frame_done` per vs rise in RUN/ARMED. Vs held high for N cycles yields exactly one pulse.
- **Zone boundaries:** pixel x = `(z+1)<<ZONE_SHIFT` belongs to zone z+1; x = `((z+1)<<ZONE_SHIFT) - 1` belongs to zone z.
- **Sync delay:** `point_vs(t)` = `bin2_vs(t - DELAY_CYCLES)`, and likewise for de.

## Test plan
Configuration: `COORD_WID=11`, `ZONE_SHIFT=3`, `NUM_ZONES=2`, `MIN_PIX=2`; 16-px lines, 8 lines per frame.
- **First frame suppressed:** reset, frame 1 with pixels at (2,1),(5,3) → no `frame_done` at the first vs rise (IDLE→ARMED), all outputs 0. Frame 2, identical → `frame_done` at the second vs rise with zone0 = {xmin 2, xmax 5, ymin 1, ymax 3}, cnt 2, `zone_valid` = 2'b01.
- **Zone split and MIN_PIX:** pixels at (7,0),(8,0),(9,6) → zone0 cnt 1, invalid, all fields 0. Zone1 = {8, 9, 0, 6}, cnt 2, `zone_valid` = 2'b10.
- **Out-of-range zone:** pixel at x = 16 (line extended to 20 px) → ignored; all cnt 0, `zone_valid` = 0, `frame_done` still pulses.
- **Vs precedence:** `bin2_de` = 1, data = 1 on the same cycle as vs rise → pixel not counted in the next frame; `frame_done` exactly 1 cycle wide with vs held high for 5 cycles.
- **Reset mid-frame:** deassert `rstn_out` at line 4 → outputs 0 immediately; the next vs rise gives no `frame_done`, the following one does.
- **Sync delay and saturation:** `DELAY_CYCLES=3`, random vs/de → `point_vs`/`point_de` match the inputs delayed by 3 cycles. `CNT_WID=3`, 10 foreground pixels in zone0 → cnt 7.
